// File: rtl/multicycle_ctrl_v2_if.sv
// rtl/multicycle_ctrl_v2_if.sv - opcode/memory-handshake inputs and datapath control outputs of the control FSM
interface multicycle_ctrl_v2_if #(
    parameter int OPW  = 5,
    parameter int ALUW = 3
);
    logic [OPW-1:0]  opcode;
    logic            mem_ready;
    logic            RegWrite;
    logic            ALUSrc;
    logic            MemRead;
    logic            MemWrite;
    logic            MemToReg;
    logic            PCWrite;
    logic            PCSrc;
    logic            ExtSel;
    logic [ALUW-1:0] ALUCtrl;
    logic            IRWrite;
    logic            AddrSel;
    logic            SPInc;
    logic            SPDec;
    logic            LinkWrite;
    logic            halted;
    logic [1:0]      err_code;
    logic [3:0]      state_o;

    modport master (
        input  opcode, mem_ready,
        output RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, PCWrite, PCSrc, ExtSel,
        output ALUCtrl, IRWrite, AddrSel, SPInc, SPDec, LinkWrite, halted, err_code, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, PCWrite, PCSrc, ExtSel,
        input  ALUCtrl, IRWrite, AddrSel, SPInc, SPDec, LinkWrite, halted, err_code, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// rtl/multicycle_ctrl_v2.sv - multi-cycle control FSM with stack ops, memory-ready watchdog, JAL link and sticky errors
module multicycle_ctrl_v2 #(
    parameter int OPW      = 5,
    parameter int ALUW     = 3,
    parameter int WAIT_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_ctrl_v2_if.master  bus
);
    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

    typedef enum logic [3:0] {
        S_FETCH       = 4'd0,
        S_DECODE      = 4'd1,
        S_EXECUTE     = 4'd2,
        S_WB_ALU      = 4'd3,
        S_MEM_READ    = 4'd4,
        S_WB_LD       = 4'd5,
        S_MEM_WRITE   = 4'd6,
        S_STACK_DEC   = 4'd7,
        S_STACK_WRITE = 4'd8,
        S_STACK_READ  = 4'd9,
        S_POP_WB      = 4'd10,
        S_JUMP_JAL    = 4'd11,
        S_HALT        = 4'd12,
        S_ERROR       = 4'd13
    } state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [1:0]      err, err_nxt;
    logic [4:0]      op;
    logic            hi_bad;
    logic            itype;
    logic            in_wait;
    logic            timeout;

    logic            reg_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic            pc_write, pc_src, ext_sel, ir_write, addr_sel;
    logic            sp_inc, sp_dec, link_write, halted_r;
    logic [ALUW-1:0] alu;

    assign op    = bus.opcode[4:0];
    assign itype = (op[4:2] == 3'b001);

    generate
        if (OPW > 5) begin : g_hi
            assign hi_bad = |bus.opcode[OPW-1:5];
        end else begin : g_no_hi
            assign hi_bad = 1'b0;
        end
    endgenerate

    assign in_wait = (state == S_MEM_READ) || (state == S_MEM_WRITE) ||
                     (state == S_STACK_WRITE) || (state == S_STACK_READ);
    assign timeout = in_wait && !bus.mem_ready && (WAIT_MAX != 0) && (cnt == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            cnt   <= '0;
            err   <= 2'b00;
        end else begin
            state <= nxt;
            err   <= err_nxt;
            // Counter restarts whenever a wait state is entered or left
            if (!in_wait || (nxt != state)) begin
                cnt <= '0;
            end else if (!bus.mem_ready && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt        = S_FETCH;
        err_nxt    = err;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ext_sel    = 1'b0;
        ir_write   = 1'b0;
        addr_sel   = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        link_write = 1'b0;
        halted_r   = 1'b0;
        alu        = '0;

        case (state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                nxt      = S_DECODE;
            end
            S_DECODE: begin
                casez (op)
                    5'b00???:         nxt = S_EXECUTE;
                    5'b0101?:         nxt = S_JUMP_JAL;
                    5'b01100:         nxt = S_MEM_READ;
                    5'b01101:         nxt = S_MEM_WRITE;
                    5'b01110:         nxt = S_STACK_DEC;
                    5'b01111:         nxt = S_STACK_READ;
                    5'b11111:         nxt = S_HALT;
                    default:          nxt = S_ERROR;
                endcase
                if (hi_bad) begin
                    nxt = S_ERROR;
                end
                if (nxt == S_ERROR) begin
                    err_nxt = 2'b01;
                end
            end
            S_EXECUTE: begin
                alu     = ALUW'(op[2:0]);
                alu_src = itype;
                ext_sel = itype;
                nxt     = S_WB_ALU;
            end
            S_WB_ALU: begin
                alu       = ALUW'(op[2:0]);
                alu_src   = itype;
                ext_sel   = itype;
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                ext_sel  = 1'b1;
                nxt      = bus.mem_ready ? S_WB_LD : S_MEM_READ;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                ext_sel   = 1'b1;
                nxt       = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_STACK_DEC: begin
                sp_dec = 1'b1;
                nxt    = S_STACK_WRITE;
            end
            S_STACK_WRITE: begin
                mem_write = 1'b1;
                addr_sel  = 1'b1;
                nxt       = bus.mem_ready ? S_FETCH : S_STACK_WRITE;
            end
            S_STACK_READ: begin
                mem_read = 1'b1;
                addr_sel = 1'b1;
                nxt      = bus.mem_ready ? S_POP_WB : S_STACK_READ;
            end
            S_POP_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                sp_inc     = 1'b1;
                nxt        = S_FETCH;
            end
            S_JUMP_JAL: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                if (op == 5'b01011) begin
                    reg_write  = 1'b1;
                    link_write = 1'b1;
                end
                nxt = S_FETCH;
            end
            S_HALT: begin
                halted_r = 1'b1;
                nxt      = S_HALT;
            end
            S_ERROR: begin
                halted_r = 1'b1;
                nxt      = S_ERROR;
            end
            default: nxt = S_FETCH;
        endcase

        if (timeout) begin
            nxt     = S_ERROR;
            err_nxt = 2'b10;
        end
    end

    // Reset blanks every output at once so an aborted instruction leaves no partial write
    assign bus.RegWrite  = reset_n & reg_write;
    assign bus.ALUSrc    = reset_n & alu_src;
    assign bus.MemRead   = reset_n & mem_read;
    assign bus.MemWrite  = reset_n & mem_write;
    assign bus.MemToReg  = reset_n & mem_to_reg;
    assign bus.PCWrite   = reset_n & pc_write;
    assign bus.PCSrc     = reset_n & pc_src;
    assign bus.ExtSel    = reset_n & ext_sel;
    assign bus.IRWrite   = reset_n & ir_write;
    assign bus.AddrSel   = reset_n & addr_sel;
    assign bus.SPInc     = reset_n & sp_inc;
    assign bus.SPDec     = reset_n & sp_dec;
    assign bus.LinkWrite = reset_n & link_write;
    assign bus.halted    = reset_n & halted_r;
    assign bus.ALUCtrl   = reset_n ? alu : '0;
    assign bus.err_code  = reset_n ? err : 2'b00;
    assign bus.state_o   = reset_n ? state : 4'd0;
endmodule

// File: doc/multicycle_ctrl_v2.md
# multicycle_ctrl_v2

Parametrised multi-cycle control FSM that sequences the datapath through fetch, decode, execute, memory and write-back phases. Adds over the previous generation: implemented stack operations (PUSH/POP with SP control), a data-memory ready handshake with a timeout watchdog, link-register control for JAL, a HALT instruction and sticky error reporting. It sits between the instruction register/opcode field and every datapath mux and write enable.

## Interface
- OPW, 5: opcode width. Must be ≥ 5; decode uses opcode[4:0], and any nonzero opcode[OPW-1:5] is illegal.
- ALUW, 3: ALUCtrl width. Must be ≥ 3; the value is opcode[2:0] zero-extended.
- WAIT_MAX, 8: maximum consecutive mem_ready-low cycles in a memory state. 0 disables the timeout.
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  OPW  opcode from the instruction register; stable from DECODE until the next FETCH
- mem_ready  in  1  data memory completed the current access
- RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, PCWrite, PCSrc, ExtSel  out  1 each  datapath controls, same meaning as the previous control unit
- ALUCtrl  out  ALUW  ALU operation
- IRWrite  out  1  latch the instruction
- AddrSel  out  1  data address source: 1 = SP, 0 = ALU result
- SPInc, SPDec  out  1 each  stack-pointer adjust by one, applied at the clock edge
- LinkWrite  out  1  select PC+1 as the register write data (JAL)
- halted  out  1  FSM is in HALT or ERROR
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
- state_o  out  4  current state, for debug

## Operation
- State encoding:
  - FETCH=0, DECODE=1, EXECUTE=2, WB_ALU=3
  - MEM_READ=4, WB_LD=5, MEM_WRITE=6
  - STACK_DEC=7, STACK_WRITE=8, STACK_READ=9, POP_WB=10
  - JUMP_JAL=11, HALT=12, ERROR=13
  - Encodings 14 and 15 go to FETCH.
- Outputs are combinational from state and opcode. Every output not listed below for a state is 0.
- FETCH: IRWrite=1, PCWrite=1, ALUCtrl=0. Next: DECODE.
- DECODE, next state by opcode:
  - 000xx, 001xx → EXECUTE
  - 01010 (JUMP), 01011 (JAL) → JUMP_JAL
  - 01100 (LD) → MEM_READ
  - 01101 (ST) → MEM_WRITE
  - 01110 (PUSH) → STACK_DEC
  - 01111 (POP) → STACK_READ
  - 11111 (HLT) → HALT
  - Any other opcode → ERROR, with err_code=01.
- EXECUTE: ALUCtrl=opcode[2:0]. For I-type (001xx), ALUSrc=1 and ExtSel=1. Next: WB_ALU.
- WB_ALU: ALUCtrl=opcode[2:0], ALUSrc and ExtSel as in EXECUTE, RegWrite=1. Next: FETCH.
- MEM_READ: MemRead=1, ALUSrc=1, ExtSel=1, ALUCtrl=000. Waits for mem_ready, then goes to WB_LD.
- WB_LD: RegWrite=1, MemToReg=1. Next: FETCH.
- MEM_WRITE: MemWrite=1, ALUSrc=1, ExtSel=1, ALUCtrl=000. Waits for mem_ready, then goes to FETCH.
- STACK_DEC: SPDec=1. Next: STACK_WRITE.
- STACK_WRITE: MemWrite=1, AddrSel=1. Waits for mem_ready, then goes to FETCH.
- STACK_READ: MemRead=1, AddrSel=1. Waits for mem_ready, then goes to POP_WB.
- POP_WB: RegWrite=1, MemToReg=1, SPInc=1. Next: FETCH.
- JUMP_JAL: PCWrite=1, PCSrc=1. If opcode is 01011, also RegWrite=1 and LinkWrite=1. Next: FETCH.
- HALT: halted=1. Self-loop; only reset exits.
- ERROR: halted=1, err_code holds its value. Self-loop; only reset exits.
- Wait states are MEM_READ, MEM_WRITE, STACK_WRITE and STACK_READ. In a wait state:
  - A counter clears on entry and increments every cycle mem_ready=0.
  - mem_ready=1 at a clock edge advances the FSM.
  - mem_ready=0 with counter = WAIT_MAX−1 (and WAIT_MAX≠0) goes to ERROR, with err_code=10.
- Counter width is clog2(WAIT_MAX+1), minimum 1 bit. It saturates, never wraps.

## Timing
- While reset_n=0, all outputs are forced to 0 and state_o=0.
  - state, counter and err_code reset asynchronously to FETCH, 0 and 00.
  - The first rising edge after reset_n deasserts leaves FETCH.
- Reset mid-instruction aborts it immediately. The outputs drop in the same cycle as reset assertion, with no partial write-back.
- Latency with mem_ready=1 on first sample:
  - R/I-type: 4 cycles (FETCH, DECODE, EXECUTE, WB_ALU)
  - LD: 4 cycles
  - ST: 3 cycles
  - JUMP/JAL: 3 cycles
  - PUSH: 4 cycles
  - POP: 4 cycles
  - HLT: reaches HALT after 2 cycles
- Each cycle of mem_ready=0 adds one cycle. Memory controls stay asserted for the whole wait.
- mem_ready is ignored outside wait states.
- SPDec and SPInc are each asserted for exactly one cycle per PUSH/POP.
- err_code is sticky: it is written once on entry to ERROR and cleared only by reset.

## Test plan
- Reset release, then ADD opcode 00000: state_o runs 0,1,2,3,0. RegWrite=1 only in cycle 4. ALUSrc=0 throughout.
- ADDI 00100: ALUSrc=1 and ExtSel=1 in EXECUTE and WB_ALU. ALUCtrl=100.
- LD with mem_ready held low 3 cycles then high: MemRead=1 for 4 cycles, then WB_LD with RegWrite=1 and MemToReg=1. Total 7 cycles.
- PUSH then POP, mem_ready=1:
  - PUSH: SPDec pulses once in cycle 3, and MemWrite with AddrSel=1 in cycle 4.
  - POP: MemRead with AddrSel=1, then RegWrite, MemToReg and SPInc together in one cycle.
- ST with mem_ready stuck low, WAIT_MAX=8: MemWrite=1 for 8 cycles, then state_o=13, halted=1, err_code=10. These hold until reset_n is pulsed.
- Opcode 10000: ERROR after DECODE with err_code=01. HLT 11111: state_o=12, halted=1, err_code=00. Assert reset_n=0 mid-EXECUTE: all outputs 0 immediately, state_o=0.
